// File: rtl/flash_cmd_sched_if.sv
// flash_cmd_sched_if: command request and read-response bundle between two requesters and the SPI flash sequencer
//   master: requester side (drives req_*, receives req_ready and rsp_*)
//   slave : sequencer side (receives req_*, drives req_ready and rsp_*)
interface flash_cmd_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_cmd;
    logic [47:0] req_addr;
    logic [1:0]  req_has_addr;
    logic [7:0]  req_dummy;
    logic [15:0] req_len;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_id;
    logic        rsp_last;
    modport master (
        output req_valid, req_cmd, req_addr, req_has_addr, req_dummy, req_len,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
    );
    modport slave (
        input  req_valid, req_cmd, req_addr, req_has_addr, req_dummy, req_len,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
    );
endinterface

// File: rtl/flash_cmd_sched.sv
// flash_cmd_sched: round-robin arbiter and SPI mode-0 command sequencer (opcode, address, dummy, read bytes)
//   clk, rst          : clock, synchronous active-high reset
//   bus               : requester commands in, tagged read bytes out
//   busy, grant_id    : transaction in progress, current/most recent requester
//   ce, sclk, dout    : flash chip enable (active-low), SPI clock, MOSI
//   din               : flash MISO
module flash_cmd_sched #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    flash_cmd_sched_if.slave        bus,
    output logic                    busy,
    output logic                    grant_id,
    output logic                    ce,
    output logic                    sclk,
    output logic                    dout,
    input  logic                    din
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_TC = GW'(CS_GAP);
    state_t        state, nxt;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [4:0]    bit_cnt;
    logic [7:0]    byte_cnt, len, cmd_g, len_g;
    logic [3:0]    dummy, dummy_g;
    logic [23:0]   addr_g;
    logic [30:0]   sh;
    logic [6:0]    rx;
    logic          has_addr, has_addr_g, last_grant, g, accept, tick, rise, fall, phase_end, byte_end;
    always_comb begin
        g          = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
        accept     = !rst && state == IDLE && |bus.req_valid;
        cmd_g      = g ? bus.req_cmd[15:8] : bus.req_cmd[7:0];
        addr_g     = g ? bus.req_addr[47:24] : bus.req_addr[23:0];
        has_addr_g = g ? bus.req_has_addr[1] : bus.req_has_addr[0];
        dummy_g    = g ? bus.req_dummy[7:4] : bus.req_dummy[3:0];
        len_g      = g ? bus.req_len[15:8] : bus.req_len[7:0];
        bus.req_ready = accept ? {g, ~g} : 2'b00;
        busy       = state != IDLE || accept;
        tick       = div_cnt == DIV_TC;
        rise       = tick && !sclk;
        fall       = tick && sclk;
        byte_end   = bit_cnt == 5'd7;
        phase_end  = state == CMD   ? byte_end :
                     state == ADDR  ? bit_cnt == 5'd23 :
                     state == DUMMY ? bit_cnt + 5'd1 == {1'b0, dummy} :
                     byte_end && byte_cnt + 8'd1 == len;
        // empty phases are skipped by falling straight through to the next non-empty one
        nxt        = (state == CMD && has_addr) ? ADDR :
                     ((state == CMD || state == ADDR) && dummy != 4'd0) ? DUMMY :
                     (state != DATA && len != 8'd0) ? DATA : GAP;
    end
    always_ff @(posedge clk) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_last  <= 1'b0;
        if (rst) begin
            state        <= IDLE;
            ce           <= 1'b1;
            sclk         <= 1'b0;
            dout         <= 1'b0;
            div_cnt      <= '0;
            gap_cnt      <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            len          <= '0;
            dummy        <= '0;
            has_addr     <= 1'b0;
            sh           <= '0;
            rx           <= '0;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state      <= CMD;
                    ce         <= 1'b0;
                    sclk       <= 1'b0;
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                    dout       <= cmd_g[7];
                    sh         <= {cmd_g[6:0], addr_g};
                    has_addr   <= has_addr_g;
                    dummy      <= dummy_g;
                    len        <= len_g;
                    grant_id   <= g;
                    last_grant <= g;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_TC) state <= IDLE;
                end
                default: begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    if (tick) sclk <= ~sclk;
                    if (rise && state == DATA) begin
                        rx <= {rx[5:0], din};
                        if (byte_end) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= {rx, din};
                            bus.rsp_id    <= grant_id;
                            bus.rsp_last  <= byte_cnt + 8'd1 == len;
                        end
                    end
                    if (fall) begin
                        sh <= sh << 1;
                        if (phase_end) begin
                            state   <= nxt;
                            bit_cnt <= '0;
                            dout    <= nxt == ADDR ? sh[30] : 1'b0;
                            if (nxt == GAP) begin
                                ce      <= 1'b1;
                                gap_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= (state == DATA && byte_end) ? 5'd0 : bit_cnt + 5'd1;
                            if (state == DATA && byte_end) byte_cnt <= byte_cnt + 8'd1;
                            dout    <= (state == CMD || state == ADDR) ? sh[30] : 1'b0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flash_cmd_sched.sv
// tb_flash_cmd_sched: directed checks of arbitration, SPI framing and byte delivery against a behavioural flash
module tb_flash_cmd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, grant_id, ce, sclk, dout, din = 1'b0;
    logic busy2, grant_id2, ce2, sclk2, dout2, din2 = 1'b0;
    int   checks = 0, errors = 0;
    flash_cmd_sched_if bus ();
    flash_cmd_sched_if bus2 ();
    flash_cmd_sched #(.CLK_DIV(2), .CS_GAP(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .grant_id(grant_id),
        .ce(ce), .sclk(sclk), .dout(dout), .din(din)
    );
    flash_cmd_sched #(.CLK_DIV(1), .CS_GAP(4)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .grant_id(grant_id2),
        .ce(ce2), .sclk(sclk2), .dout(dout2), .din(din2)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    // flash: opcode picks the header length and the bytes returned; data shifts out on sclk falls
    function automatic logic fbit(input logic [7:0] op, input int k);
        int s;
        logic [23:0] d;
        s = op == 8'h9F ? 8 : op == 8'h0B ? 40 : 32;
        d = op == 8'h9F ? 24'hEF4018 : op == 8'h0B ? 24'hA53C00 : 24'h112233;
        if (k < s || k - s > 23) return 1'b0;
        return d[23 - (k - s)];
    endfunction
    int          fl_rise, fl_fall, f2;
    logic [63:0] fl_sr;
    logic [7:0]  fl_op;
    always @(negedge ce) begin fl_rise = 0; fl_fall = 0; fl_sr = '0; fl_op = '0; end
    always @(posedge sclk) begin
        fl_sr = {fl_sr[62:0], dout};
        fl_rise++;
        if (fl_rise == 8) fl_op = fl_sr[7:0];
    end
    always @(negedge sclk) begin fl_fall++; din = fbit(fl_op, fl_fall); end
    always @(negedge ce2) f2 = 0;
    always @(negedge sclk2) begin f2++; din2 = f2[0]; end
    int          cyc = 0, n_tr = 0, n_rsp = 0, n_g = 0;
    int          ce_fall_cyc = 0, ce_rise_cyc = 0, busy_fall_cyc = 0;
    int          tr_len [16], tr_gap [16], tr_rises [16];
    logic [63:0] tr_sr [16];
    logic        tr_gid [16], g_seq [16], rsp_i [16], rsp_l [16];
    logic [7:0]  rsp_d [16];
    int          rsp_c [16];
    logic        ce_q = 1'b1, busy_q = 1'b0, ce2_q = 1'b1;
    int          c2_fall = 0, c2_len = 0, c2_prev = 0, n2 = 0, bad_sp = 0, bad_d = 0, n_last = 0, last_at = 0;
    always @(negedge clk) begin
        cyc++;
        if (ce_q && !ce) begin
            if (n_tr < 16) tr_gap[n_tr] = cyc - ce_rise_cyc;
            ce_fall_cyc = cyc;
        end
        if (!ce_q && ce) begin
            if (n_tr < 16) begin
                tr_len[n_tr] = cyc - ce_fall_cyc;
                tr_rises[n_tr] = fl_rise;
                tr_sr[n_tr] = fl_sr;
                tr_gid[n_tr] = grant_id;
            end
            n_tr++;
            ce_rise_cyc = cyc;
        end
        if (busy_q && !busy) busy_fall_cyc = cyc;
        if (|bus.req_ready) begin
            if (n_g < 16) g_seq[n_g] = bus.req_ready[1];
            n_g++;
        end
        if (bus.rsp_valid) begin
            if (n_rsp < 16) begin
                rsp_d[n_rsp] = bus.rsp_data;
                rsp_i[n_rsp] = bus.rsp_id;
                rsp_l[n_rsp] = bus.rsp_last;
                rsp_c[n_rsp] = cyc;
            end
            n_rsp++;
        end
        if (ce2_q && !ce2) c2_fall = cyc;
        if (!ce2_q && ce2) c2_len = cyc - c2_fall;
        if (bus2.rsp_valid) begin
            if (n2 > 0 && cyc - c2_prev != 16) bad_sp++;
            if (bus2.rsp_data != 8'h55) bad_d++;
            if (bus2.rsp_last) begin n_last++; last_at = n2 + 1; end
            c2_prev = cyc;
            n2++;
        end
        ce_q = ce;
        busy_q = busy;
        ce2_q = ce2;
    end
    int nb, nr, t0;
    initial begin
        bus.req_cmd = {8'h0B, 8'h9F};
        bus.req_addr = {24'h123456, 24'h000000};
        bus.req_has_addr = 2'b10;
        bus.req_dummy = {4'd8, 4'd0};
        bus.req_len = {8'd2, 8'd3};
        bus.req_valid = 2'b11;
        bus2.req_cmd = 16'h0003;
        bus2.req_addr = '0;
        bus2.req_has_addr = 2'b00;
        bus2.req_dummy = '0;
        bus2.req_len = {8'd0, 8'd255};
        bus2.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_pins", {ce, sclk, dout}, 3'b100);
        check("rst_ready", bus.req_ready, 2'b00);
        check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_last, bus.rsp_data}, 11'h000);
        check("rst_busy_gid", {busy, grant_id}, 2'b00);
        rst = 1'b0;
        // contention: both held valid, grants alternate starting with requester 0
        for (int i = 0; i < 3000 && n_g < 4; i++) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3000 && !(n_tr >= 4 && !busy); i++) @(posedge clk);
        check("wait_contention", n_tr >= 4, 1'b1);
        check("grant_seq", {g_seq[0], g_seq[1], g_seq[2], g_seq[3]}, 4'b0101);
        check("jedec_ce_low", tr_len[0], 128);
        check("jedec_sclk", tr_rises[0], 32);
        check("jedec_gid", tr_gid[0], 1'b0);
        check("fast_ce_low", tr_len[1], 224);
        check("fast_wire", tr_sr[1][55:0], 56'h0B123456000000);
        check("fast_gid", tr_gid[1], 1'b1);
        check("gap_min", tr_gap[1] >= 6 && tr_gap[2] >= 6 && tr_gap[3] >= 6, 1'b1);
        check("rsp_count", n_rsp, 10);
        check("jedec_data", {rsp_d[0], rsp_d[1], rsp_d[2]}, 24'hEF4018);
        check("jedec_id_last", {rsp_i[0], rsp_i[1], rsp_i[2], rsp_l[0], rsp_l[1], rsp_l[2]}, 6'b000001);
        check("fast_data", {rsp_d[3], rsp_d[4]}, 16'hA53C);
        check("fast_id_last", {rsp_i[3], rsp_i[4], rsp_l[3], rsp_l[4]}, 4'b1101);
        check("byte_spacing", {rsp_c[1] - rsp_c[0], rsp_c[4] - rsp_c[3]}, {32'd32, 32'd32});
        check("round2_data", {rsp_d[5], rsp_d[7], rsp_d[8], rsp_d[9]}, 32'hEF18A53C);
        // command only: opcode 0x06, no data phase
        @(negedge clk);
        bus.req_cmd[7:0] = 8'h06;
        bus.req_has_addr[0] = 1'b0;
        bus.req_dummy[3:0] = 4'd0;
        bus.req_len[7:0] = 8'd0;
        bus.req_valid = 2'b01;
        nb = n_rsp;
        for (int i = 0; i < 100 && n_g < 5; i++) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        for (int i = 0; i < 300 && n_tr < 5; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        check("wren_grant", g_seq[4], 1'b0);
        check("wren_ce_low", tr_len[4], 32);
        check("wren_sclk", tr_rises[4], 8);
        check("wren_no_rsp", n_rsp, nb);
        check("wren_busy_fall", busy_fall_cyc - ce_rise_cyc, 5);
        // reset during the second byte of a 3-byte read
        @(negedge clk);
        bus.req_cmd[7:0] = 8'h03;
        bus.req_addr[23:0] = 24'h000000;
        bus.req_has_addr[0] = 1'b1;
        bus.req_len[7:0] = 8'd3;
        bus.req_valid = 2'b01;
        nb = n_rsp;
        for (int i = 0; i < 100 && n_g < 6; i++) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (3) @(posedge clk);
        t0 = ce_fall_cyc;
        for (int i = 0; i < 400 && cyc - t0 < 170; i++) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req_cmd[7:0] = 8'h06;
        bus.req_has_addr[0] = 1'b0;
        bus.req_len[7:0] = 8'd0;
        bus.req_valid = 2'b11;
        nr = n_rsp;
        @(negedge clk);
        check("midrst_pins", {ce, sclk, dout}, 3'b100);
        check("midrst_partial", nr - nb, 1);
        check("midrst_byte1", rsp_d[nb], 8'h11);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100 && n_g < 7; i++) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("postrst_grant", g_seq[6], 1'b0);
        for (int i = 0; i < 300 && ce; i++) @(posedge clk);
        for (int i = 0; i < 300 && !ce; i++) @(posedge clk);
        repeat (10) @(posedge clk);
        check("postrst_no_rsp", n_rsp, nr);
        // CLK_DIV=1, 255-byte read
        @(negedge clk);
        bus2.req_valid = 2'b01;
        for (int i = 0; i < 20 && ce2; i++) @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 2'b00;
        for (int i = 0; i < 6000 && !(n2 >= 255 && ce2); i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("long_count", n2, 255);
        check("long_spacing_bad", bad_sp, 0);
        check("long_data_bad", bad_d, 0);
        check("long_last", {n_last, last_at}, {32'd1, 32'd255});
        check("long_ce_low", c2_len, 4096);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
